// File: rtl/cpu_multicycle_if.sv
// Instruction/data memory bus of cpu_multicycle: two independent req/ready channels.
// master = core side, slave = memory side.
interface cpu_multicycle_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ready;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle 16-bit-instruction core, FSM FETCH/EXEC/MEM/HALT with req/ready memories.
// Optional feature: define CPU_SUB_EN to decode opcode D as SUB (otherwise NOP).
module cpu_multicycle #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu_multicycle_if.master      bus,
    output logic [ADDR_W-1:0]     pc,
    output logic                  halted,
    output logic                  retire
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_JNC  = 4'hC;
`ifdef CPU_SUB_EN
    localparam logic [3:0] OP_SUB  = 4'hD;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic              retire_q;
    logic [DATA_W-1:0] regs_q [16];

    logic              commit;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              imem_req_c;
    logic              dmem_req_c;

    logic [3:0]        op, rd, rs1, rs2;
    logic [DATA_W-1:0] opa, opb, opd, imm;
    logic [ADDR_W-1:0] pc_inc, pc_br;

    assign op     = instr_q[15:12];
    assign rd     = instr_q[11:8];
    assign rs1    = instr_q[7:4];
    assign rs2    = instr_q[3:0];
    assign opa    = regs_q[rs1];
    assign opb    = regs_q[rs2];
    assign opd    = regs_q[rd];
    assign imm    = DATA_W'(instr_q[3:0]);
    assign pc_inc = pc_q + ADDR_W'(1);
    // Branch offset is zero-extended and the sum wraps at 2^ADDR_W.
    assign pc_br  = pc_q + ADDR_W'(instr_q[11:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            retire_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            retire_q <= commit;
            if (rf_we) begin
                regs_q[rd] <= rf_wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        instr_q <= instr_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        zf_d       = zf_q;
        cf_d       = cf_q;
        commit     = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                commit  = 1'b1;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = opa + opb;
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = opa + imm;
                    end
                    OP_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = opa & opb;
                    end
                    OP_ANDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = opa & imm;
                    end
                    OP_LD, OP_ST: begin
                        state_d = S_MEM;
                        commit  = 1'b0;
                        pc_d    = pc_q;
                    end
                    OP_CMP: begin
                        zf_d = (opa == opb);
                        cf_d = (opa < opb);
                    end
`ifdef CPU_SUB_EN
                    OP_SUB: begin
                        rf_we    = 1'b1;
                        rf_wdata = opa - opb;
                        zf_d     = (opa == opb);
                        cf_d     = (opa < opb);
                    end
`endif
                    OP_JMP: pc_d = pc_br;
                    OP_JZ:  if (zf_q)  pc_d = pc_br;
                    OP_JNZ: if (!zf_q) pc_d = pc_br;
                    OP_JC:  if (cf_q)  pc_d = pc_br;
                    OP_JNC: if (!cf_q) pc_d = pc_br;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end

            S_MEM: begin
                dmem_req_c = 1'b1;
                if (bus.dmem_ready) begin
                    if (op == OP_LD) begin
                        rf_we    = 1'b1;
                        rf_wdata = bus.dmem_rdata;
                    end
                    commit  = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase
    end

    // Requests are masked while reset is held so an aborted access drops immediately.
    assign bus.imem_req   = imem_req_c & ~reset;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_c & ~reset;
    assign bus.dmem_we    = dmem_req_c & ~reset & (op == OP_ST);
    assign bus.dmem_addr  = ADDR_W'(instr_q[7:0]);
    assign bus.dmem_wdata = opd;

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);
    assign retire = retire_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: ISA-level reference model plus directed programs.
module tb_cpu_multicycle;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              retire;

    cpu_multicycle_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cpu_multicycle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(12'h000)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus.master),
        .pc     (pc),
        .halted (halted),
        .retire (retire)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memories seen by the core, with configurable wait states.
    logic [15:0]       imem [4096];
    logic [DATA_W-1:0] dmem [256];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

    always @(negedge clock) begin
        if (bus.imem_req) begin
            if (icnt >= iwait) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = imem[bus.imem_addr];
                icnt = 0;
            end else begin
                bus.imem_ready = 1'b0;
                icnt++;
            end
        end else begin
            bus.imem_ready = 1'b0;
            icnt = 0;
        end
        if (bus.dmem_req) begin
            if (dcnt >= dwait) begin
                bus.dmem_ready = 1'b1;
                bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
                if (bus.dmem_we && !reset) dmem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
                dcnt = 0;
            end else begin
                bus.dmem_ready = 1'b0;
                dcnt++;
            end
        end else begin
            bus.dmem_ready = 1'b0;
            dcnt = 0;
        end
    end

    // Architectural reference model: one call executes one whole instruction.
    logic [ADDR_W-1:0] m_pc;
    logic [DATA_W-1:0] m_r [16];
    logic [DATA_W-1:0] m_dmem [256];
    bit                m_zf, m_cf, m_halted;

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_zf = 0; m_cf = 0; m_halted = 0;
    endtask

    task automatic model_step();
        logic [15:0] ins;
        logic [DATA_W-1:0] a, b;
        int nxt, tgt;
        ins = imem[m_pc];
        a   = m_r[ins[7:4]];
        b   = m_r[ins[3:0]];
        nxt = (int'(m_pc) + 1) % (1 << ADDR_W);
        tgt = (int'(m_pc) + int'(ins[11:0])) % (1 << ADDR_W);
        case (ins[15:12])
            4'h1: m_r[ins[11:8]] = DATA_W'((int'(a) + int'(b)) % (1 << DATA_W));
            4'h2: m_r[ins[11:8]] = DATA_W'((int'(a) + int'(ins[3:0])) % (1 << DATA_W));
            4'h3: m_r[ins[11:8]] = a & b;
            4'h4: m_r[ins[11:8]] = a & DATA_W'(ins[3:0]);
            4'h5: m_r[ins[11:8]] = m_dmem[ins[7:0]];
            4'h6: m_dmem[ins[7:0]] = m_r[ins[11:8]];
            4'h7: begin m_zf = (a == b); m_cf = (a < b); end
            4'h8: nxt = tgt;
            4'h9: if (m_zf)  nxt = tgt;
            4'hA: if (!m_zf) nxt = tgt;
            4'hB: if (m_cf)  nxt = tgt;
            4'hC: if (!m_cf) nxt = tgt;
`ifdef CPU_SUB_EN
            4'hD: begin
                m_r[ins[11:8]] = DATA_W'((int'(a) - int'(b) + (1 << DATA_W)) % (1 << DATA_W));
                m_zf = (a == b);
                m_cf = (a < b);
            end
`endif
            4'hF: m_halted = 1;
            default: ;
        endcase
        m_pc = ADDR_W'(nxt);
    endtask

    // Per-retire log used by the directed literal checks.
    logic [ADDR_W-1:0] ret_pc [$];
    int                ret_dur [$];
    int                cyc = 0, last_ret = 0;
    bit                prev_dreq = 0;
    logic [ADDR_W-1:0] prev_daddr;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_we;

    always @(negedge clock) begin
        logic [15:0] ins;
        cyc++;
        if (reset) begin
            model_reset();
            prev_dreq = 0;
            last_ret  = cyc;
        end else begin
            if (retire) begin
                model_step();
                ret_pc.push_back(pc);
                ret_dur.push_back(cyc - last_ret);
                last_ret = cyc;
            end
            check("pc", pc, m_pc);
            check("halted", halted, m_halted);
            if (m_halted) check("req_in_halt", {bus.imem_req, bus.dmem_req}, 2'b00);
            if (bus.imem_req) check("imem_addr", bus.imem_addr, m_pc);
            if (bus.dmem_req) begin
                ins = imem[m_pc];
                check("dmem_op", (ins[15:12] == 4'h5) || (ins[15:12] == 4'h6), 1);
                check("dmem_addr", bus.dmem_addr, ADDR_W'(ins[7:0]));
                check("dmem_we", bus.dmem_we, ins[15:12] == 4'h6);
                if (ins[15:12] == 4'h6) check("dmem_wdata", bus.dmem_wdata, m_r[ins[11:8]]);
                if (prev_dreq) begin
                    check("dmem_addr_stable", bus.dmem_addr, prev_daddr);
                    check("dmem_wdata_stable", bus.dmem_wdata, prev_wdata);
                    check("dmem_we_stable", bus.dmem_we, prev_we);
                end
            end
            prev_dreq  = bus.dmem_req;
            prev_daddr = bus.dmem_addr;
            prev_wdata = bus.dmem_wdata;
            prev_we    = bus.dmem_we;
        end
    end

    task automatic set_d(input int a, input logic [DATA_W-1:0] v);
        dmem[a]   = v;
        m_dmem[a] = v;
    endtask

    // Called while reset is high.
    task automatic begin_test(input int iw, input int dw);
        iwait = iw;
        dwait = dw;
        for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
        for (int i = 0; i < 256; i++) set_d(i, '0);
        ret_pc.delete();
        ret_dur.delete();
    endtask

    task automatic enter_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic release_reset();
        @(posedge clock); #1 reset = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int max, output int n);
        n = 0;
        while (!halted && n < max) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, "_halt_reached"}, halted, 1'b1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int n, k, nr;

        // Test 1: straight-line ALU program, zero wait
        begin_test(0, 0);
        imem[0] = 16'h2105;  // ADDI r1,r0,5
        imem[1] = 16'h2203;  // ADDI r2,r0,3
        imem[2] = 16'h1312;  // ADD  r3,r1,r2
        imem[3] = 16'hF000;  // HALT
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", pc, 12'h000);
        check("rst_halted", halted, 1'b0);
        check("rst_retire", retire, 1'b0);
        check("rst_reqs", {bus.imem_req, bus.dmem_req, bus.dmem_we}, 3'b000);
        release_reset();
        wait_halt("t1", 100, n);
        check("t1_cycles_to_halt", n, 8);
        check("t1_retire_count", ret_pc.size(), 4);
        check("t1_final_pc", pc, 12'h004);

        // Test 2: store then load with three data wait states
        enter_reset();
        begin_test(0, 3);
        imem[0] = 16'h2105;
        imem[1] = 16'h2203;
        imem[2] = 16'h1312;
        imem[3] = 16'h6310;  // ST r3,0x10
        imem[4] = 16'h5410;  // LD r4,0x10
        imem[5] = 16'h6411;  // ST r4,0x11
        imem[6] = 16'hF000;
        release_reset();
        wait_halt("t2", 200, n);
        check("t2_st_data", dmem[8'h10], 16'h0008);
        check("t2_ld_copy", dmem[8'h11], 16'h0008);
        check("t2_ld_cycles", (ret_dur.size() > 4) ? ret_dur[4] : -1, 6);
        check("t2_st_cycles", (ret_dur.size() > 3) ? ret_dur[3] : -1, 6);

        // Test 3: compare and conditional branches, two fetch wait states
        enter_reset();
        begin_test(2, 0);
        imem[0]     = 16'h2105;
        imem[1]     = 16'h2203;
        imem[2]     = 16'h0000;
        imem[3]     = 16'h0000;
        imem[4]     = 16'h7012;  // CMP r1,r2
        imem[5]     = 16'hC004;  // JNC +4
        imem[12'h9] = 16'h9005;  // JZ +5
        imem[12'hA] = 16'hF000;
        release_reset();
        wait_halt("t3", 200, n);
        check("t3_jnc_taken_pc", (ret_pc.size() > 5) ? ret_pc[5] : 12'hFFF, 12'h009);
        check("t3_jz_not_taken_pc", (ret_pc.size() > 6) ? ret_pc[6] : 12'hFFF, 12'h00A);

        // Test 4: PC wrap on jump
        enter_reset();
        begin_test(0, 0);
        imem[0]       = 16'h8FFE;  // JMP +0xFFE
        imem[12'hFFE] = 16'h8003;  // JMP +3 -> wraps
        imem[1]       = 16'hF000;
        release_reset();
        wait_halt("t4", 100, n);
        check("t4_pc_ffe", (ret_pc.size() > 0) ? ret_pc[0] : 12'h000, 12'hFFE);
        check("t4_pc_wrap", (ret_pc.size() > 1) ? ret_pc[1] : 12'hFFF, 12'h001);

        // Test 5: reset while a store is waiting
        enter_reset();
        begin_test(0, 50);
        imem[0] = 16'h2307;  // ADDI r3,r0,7
        imem[1] = 16'h6330;  // ST r3,0x30
        release_reset();
        k = 0;
        while (!bus.dmem_req && k < 40) begin
            @(posedge clock); #1;
            k++;
        end
        check("t5_dmem_req_seen", bus.dmem_req, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        nr = ret_pc.size();
        @(posedge clock); #1;
        check("t5_dmem_req_dropped", bus.dmem_req, 1'b0);
        check("t5_pc_reset", pc, 12'h000);
        check("t5_no_retire", retire, 1'b0);
        check("t5_retire_count", ret_pc.size(), nr);
        imem[0] = 16'h6331;  // ST r3,0x31 (r3 must read as 0)
        imem[1] = 16'hF000;
        set_d(8'h31, 16'hABCD);
        dwait = 0;
        release_reset();
        wait_halt("t5", 100, n);
        check("t5_aborted_store", dmem[8'h30], 16'h0000);
        check("t5_regs_cleared", dmem[8'h31], 16'h0000);

        // Test 6: opcode D (SUB when enabled, NOP otherwise)
        enter_reset();
        begin_test(0, 1);
        imem[0]     = 16'h2105;
        imem[1]     = 16'h2203;
        imem[2]     = 16'hD521;  // SUB r5,r2,r1
        imem[3]     = 16'h6520;  // ST r5,0x20
        imem[4]     = 16'hB002;  // JC +2
        imem[5]     = 16'hF000;
        imem[6]     = 16'hA002;  // JNZ +2
        imem[12'h8] = 16'hF000;
        set_d(8'h20, 16'h1234);
        release_reset();
        wait_halt("t6", 200, n);
`ifdef CPU_SUB_EN
        check("t6_sub_result", dmem[8'h20], 16'hFFFE);
        check("t6_final_pc", pc, 12'h009);
`else
        check("t6_d_is_nop", dmem[8'h20], 16'h0000);
        check("t6_final_pc", pc, 12'h006);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
